// File: rtl/mcu_exec_core.sv
// Execution core: instruction-decode control, 8-bit ALU with operand-2 mux,
// and a 16x8 data memory with asynchronous read and synchronous write.
module mcu_exec_core #(
    parameter int DMEM_DEPTH = 16,
    parameter int DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    stage,
    input  logic [11:0]   ir,
    input  logic [3:0]    sr,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] dr,
    output logic          pc_e,
    output logic          acc_e,
    output logic          sr_e,
    output logic          ir_e,
    output logic          dr_e,
    output logic          pmem_e,
    output logic          pmem_le,
    output logic          dmem_e,
    output logic          dmem_we,
    output logic          alu_e,
    output logic          mux1_sel,
    output logic          mux2_sel,
    output logic [3:0]    alu_mode,
    output logic [DW-1:0] alu_out,
    output logic [3:0]    flags,
    output logic [DW-1:0] dmem_do
);

    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } stage_e;

    always_comb begin
        pc_e     = 1'b0;
        acc_e    = 1'b0;
        sr_e     = 1'b0;
        ir_e     = 1'b0;
        dr_e     = 1'b0;
        pmem_e   = 1'b0;
        pmem_le  = 1'b0;
        dmem_e   = 1'b0;
        dmem_we  = 1'b0;
        alu_e    = 1'b0;
        mux1_sel = 1'b0;
        mux2_sel = 1'b0;
        alu_mode = 4'h0;
        case (stage_e'(stage))
            ST_LOAD: begin
                pmem_le = 1'b1;
                pmem_e  = 1'b1;
            end
            ST_FETCH: begin
                ir_e   = 1'b1;
                pmem_e = 1'b1;
            end
            ST_DECODE: begin
                if (ir[11:9] == 3'b001) begin
                    dr_e   = 1'b1;
                    dmem_e = 1'b1;
                end
            end
            ST_EXEC: begin
                if (ir[11]) begin
                    pc_e     = 1'b1;
                    acc_e    = 1'b1;
                    sr_e     = 1'b1;
                    alu_e    = 1'b1;
                    alu_mode = {1'b0, ir[10:8]};
                    mux1_sel = 1'b1;
                end else if (ir[10]) begin
                    // Conditional jump: a set flag selects ir[7:0] as next PC
                    pc_e     = 1'b1;
                    mux1_sel = ~sr[ir[9:8]];
                end else if (ir[9]) begin
                    pc_e     = 1'b1;
                    sr_e     = 1'b1;
                    alu_e    = 1'b1;
                    alu_mode = ir[7:4];
                    mux1_sel = 1'b1;
                    mux2_sel = 1'b1;
                    if (ir[8]) begin
                        acc_e = 1'b1;
                    end else begin
                        dmem_e  = 1'b1;
                        dmem_we = 1'b1;
                    end
                end else if (!ir[8]) begin
                    pc_e     = 1'b1;
                    mux1_sel = 1'b1;
                end else begin
                    pc_e = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [DW-1:0] op1, op2, res, ax, ay;
    logic [DW:0]   sum;
    logic [2:0]    sh;
    logic          arith, sub, f_c, f_o;

    always_comb begin
        op1   = acc;
        op2   = mux2_sel ? dr : ir[7:0];
        sh    = op1[2:0];
        res   = '0;
        ax    = '0;
        ay    = '0;
        arith = 1'b0;
        sub   = 1'b0;
        case (alu_mode)
            4'h0: begin ax = op1; ay = op2; arith = 1'b1; end
            4'h1: begin ax = op1; ay = op2; arith = 1'b1; sub = 1'b1; end
            4'h2: res = op2;
            4'h3: res = op1;
            4'h4: res = op1 & op2;
            4'h5: res = op1 | op2;
            4'h6: res = op1 ^ op2;
            4'h7: begin ax = op2; ay = op1; arith = 1'b1; sub = 1'b1; end
            4'h8: begin ax = op2; ay = DW'(1); arith = 1'b1; end
            4'h9: begin ax = op2; ay = DW'(1); arith = 1'b1; sub = 1'b1; end
            4'hA: res = DW'(({op2, op2} << sh) >> DW);
            4'hB: res = DW'({op2, op2} >> sh);
            4'hC: res = op2 << sh;
            4'hD: res = op2 >> sh;
            4'hE: res = $unsigned($signed(op2) >>> sh);
            default: begin ax = '0; ay = op2; arith = 1'b1; sub = 1'b1; end
        endcase
        sum = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
        if (arith) res = sum[DW-1:0];
        // Subtraction carry is the inverted borrow out of the extended result
        f_c = arith ? (sub ? ~sum[DW] : sum[DW]) : sr[2];
        f_o = 1'b0;
        if (arith) begin
            if (sub) f_o = (ax[DW-1] != ay[DW-1]) && (res[DW-1] != ax[DW-1]);
            else     f_o = (ax[DW-1] == ay[DW-1]) && (res[DW-1] != ax[DW-1]);
        end
        alu_out = alu_e ? res : '0;
        flags   = alu_e ? {(res == '0), f_c, res[DW-1], f_o} : sr;
    end

    logic [DW-1:0] mem_q [DMEM_DEPTH];
    logic [DW-1:0] mem_d [DMEM_DEPTH];
    logic [AW-1:0] addr;

    assign addr    = ir[AW-1:0];
    assign dmem_do = mem_q[addr];

    always_comb begin
        mem_d = mem_q;
        if (dmem_e && dmem_we) mem_d[addr] = alu_out;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_mcu_exec_core.sv
// Self-checking bench for mcu_exec_core: table of control/ALU vectors through
// a scoreboard queue, plus memory reset/write/read sequences.
module tb_mcu_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stage;
    logic [11:0] ir;
    logic [3:0]  sr;
    logic [7:0]  acc, dr;
    logic        pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le;
    logic        dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel;
    logic [3:0]  alu_mode, flags;
    logic [7:0]  alu_out, dmem_do;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mcu_exec_core #(.DMEM_DEPTH(16), .DW(8)) dut (
        .clk(clk), .rst(rst), .stage(stage), .ir(ir), .sr(sr), .acc(acc), .dr(dr),
        .pc_e(pc_e), .acc_e(acc_e), .sr_e(sr_e), .ir_e(ir_e), .dr_e(dr_e),
        .pmem_e(pmem_e), .pmem_le(pmem_le), .dmem_e(dmem_e), .dmem_we(dmem_we),
        .alu_e(alu_e), .mux1_sel(mux1_sel), .mux2_sel(mux2_sel),
        .alu_mode(alu_mode), .alu_out(alu_out), .flags(flags), .dmem_do(dmem_do)
    );

    typedef struct {
        logic [1:0]  stage;
        logic [11:0] ir;
        logic [3:0]  sr;
        logic [7:0]  acc;
        logic [7:0]  dr;
        logic [11:0] ctrl;
        logic [3:0]  mode;
        logic [7:0]  out;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [11:0] ctrl;
        logic [3:0]  mode;
        logic [7:0]  out;
        logic [3:0]  flg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(logic [1:0] st, logic [11:0] i, logic [3:0] s,
                                logic [7:0] a, logic [7:0] d, logic [11:0] c,
                                logic [3:0] m, logic [7:0] o, logic [3:0] f);
        vec_t v;
        v.stage = st; v.ir = i; v.sr = s; v.acc = a; v.dr = d;
        v.ctrl = c; v.mode = m; v.out = o; v.flg = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ctrl_vec();
        return {pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le,
                dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel};
    endfunction

    initial begin
        exp_t e;
        exp_t g;
        // ctrl bits: pc acc sr ir dr pmem_e pmem_le dmem_e dmem_we alu mux1 mux2
        vecs.push_back(mk(2'd0, 12'h000, 4'h5, 8'h12, 8'h34, 12'h060, 4'h0, 8'h00, 4'h5));
        vecs.push_back(mk(2'd1, 12'hABC, 4'hA, 8'h00, 8'h00, 12'h140, 4'h0, 8'h00, 4'hA));
        vecs.push_back(mk(2'd2, 12'h205, 4'h0, 8'h00, 8'h00, 12'h090, 4'h0, 8'h00, 4'h0));
        vecs.push_back(mk(2'd2, 12'h805, 4'h3, 8'h00, 8'h00, 12'h000, 4'h0, 8'h00, 4'h3));
        vecs.push_back(mk(2'd2, 12'h3F0, 4'h0, 8'h00, 8'h00, 12'h090, 4'h0, 8'h00, 4'h0));
        vecs.push_back(mk(2'd3, 12'h805, 4'h0, 8'hFE, 8'h00, 12'hE06, 4'h0, 8'h03, 4'h4));
        vecs.push_back(mk(2'd3, 12'h801, 4'h0, 8'hFF, 8'h00, 12'hE06, 4'h0, 8'h00, 4'hC));
        vecs.push_back(mk(2'd3, 12'hC12, 4'h0, 8'hFF, 8'h00, 12'hE06, 4'h4, 8'h12, 4'h0));
        vecs.push_back(mk(2'd3, 12'h203, 4'h0, 8'h40, 8'h40, 12'hA1F, 4'h0, 8'h80, 4'h3));
        vecs.push_back(mk(2'd3, 12'h620, 4'h4, 8'h00, 8'h00, 12'h800, 4'h0, 8'h00, 4'h4));
        vecs.push_back(mk(2'd3, 12'h620, 4'h0, 8'h00, 8'h00, 12'h802, 4'h0, 8'h00, 4'h0));
        vecs.push_back(mk(2'd3, 12'h420, 4'h1, 8'h00, 8'h00, 12'h800, 4'h0, 8'h00, 4'h1));
        vecs.push_back(mk(2'd3, 12'h720, 4'h8, 8'h00, 8'h00, 12'h800, 4'h0, 8'h00, 4'h8));
        vecs.push_back(mk(2'd3, 12'h520, 4'hD, 8'h00, 8'h00, 12'h802, 4'h0, 8'h00, 4'hD));
        vecs.push_back(mk(2'd3, 12'h117, 4'h0, 8'h00, 8'h00, 12'h800, 4'h0, 8'h00, 4'h0));
        vecs.push_back(mk(2'd3, 12'h000, 4'h9, 8'h00, 8'h00, 12'h802, 4'h0, 8'h00, 4'h9));
        vecs.push_back(mk(2'd3, 12'h310, 4'h0, 8'h05, 8'h07, 12'hE07, 4'h1, 8'hFE, 4'h2));
        vecs.push_back(mk(2'd3, 12'h310, 4'h0, 8'h80, 8'h01, 12'hE07, 4'h1, 8'h7F, 4'h5));
        vecs.push_back(mk(2'd3, 12'h320, 4'hF, 8'h11, 8'hAB, 12'hE07, 4'h2, 8'hAB, 4'h6));
        vecs.push_back(mk(2'd3, 12'h330, 4'h0, 8'h00, 8'hAB, 12'hE07, 4'h3, 8'h00, 4'h8));
        vecs.push_back(mk(2'd3, 12'h340, 4'h0, 8'hF0, 8'h3C, 12'hE07, 4'h4, 8'h30, 4'h0));
        vecs.push_back(mk(2'd3, 12'h350, 4'h0, 8'hF0, 8'h0F, 12'hE07, 4'h5, 8'hFF, 4'h2));
        vecs.push_back(mk(2'd3, 12'h360, 4'h0, 8'hAA, 8'hAA, 12'hE07, 4'h6, 8'h00, 4'h8));
        vecs.push_back(mk(2'd3, 12'h370, 4'h0, 8'h03, 8'h01, 12'hE07, 4'h7, 8'hFE, 4'h2));
        vecs.push_back(mk(2'd3, 12'h380, 4'h0, 8'h00, 8'h7F, 12'hE07, 4'h8, 8'h80, 4'h3));
        vecs.push_back(mk(2'd3, 12'h380, 4'h0, 8'h00, 8'hFF, 12'hE07, 4'h8, 8'h00, 4'hC));
        vecs.push_back(mk(2'd3, 12'h390, 4'h0, 8'h00, 8'h80, 12'hE07, 4'h9, 8'h7F, 4'h5));
        vecs.push_back(mk(2'd3, 12'h390, 4'h0, 8'h00, 8'h00, 12'hE07, 4'h9, 8'hFF, 4'h2));
        vecs.push_back(mk(2'd3, 12'h3A0, 4'h0, 8'h03, 8'h81, 12'hE07, 4'hA, 8'h0C, 4'h0));
        vecs.push_back(mk(2'd3, 12'h3B0, 4'h0, 8'h02, 8'h81, 12'hE07, 4'hB, 8'h60, 4'h0));
        vecs.push_back(mk(2'd3, 12'h3C0, 4'h0, 8'h01, 8'h81, 12'hE07, 4'hC, 8'h02, 4'h0));
        vecs.push_back(mk(2'd3, 12'h3C0, 4'h0, 8'h08, 8'h81, 12'hE07, 4'hC, 8'h81, 4'h2));
        vecs.push_back(mk(2'd3, 12'h3D0, 4'h0, 8'h01, 8'h81, 12'hE07, 4'hD, 8'h40, 4'h0));
        vecs.push_back(mk(2'd3, 12'h3E0, 4'h4, 8'h01, 8'h81, 12'hE07, 4'hE, 8'hC0, 4'h6));
        vecs.push_back(mk(2'd3, 12'h3F0, 4'h0, 8'h55, 8'h00, 12'hE07, 4'hF, 8'h00, 4'hC));
        vecs.push_back(mk(2'd3, 12'h3F0, 4'h0, 8'h00, 8'h01, 12'hE07, 4'hF, 8'hFF, 4'h2));
        vecs.push_back(mk(2'd3, 12'h3F0, 4'h0, 8'h00, 8'h80, 12'hE07, 4'hF, 8'h80, 4'h3));

        rst = 1'b0; stage = 2'd0; ir = 12'h000; sr = 4'h0; acc = 8'h00; dr = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ir = 12'(a);
            #1;
            chk($sformatf("reset_mem[%0d]", a), 32'(dmem_do), 32'h0);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            stage = vecs[k].stage; ir = vecs[k].ir; sr = vecs[k].sr;
            acc = vecs[k].acc; dr = vecs[k].dr;
            e.ctrl = vecs[k].ctrl; e.mode = vecs[k].mode;
            e.out = vecs[k].out; e.flg = vecs[k].flg;
            sb_q.push_back(e);
            #1;
            g = sb_q.pop_front();
            chk($sformatf("v%0d_ctrl", k), 32'(ctrl_vec()), 32'(g.ctrl));
            chk($sformatf("v%0d_mode", k), 32'(alu_mode), 32'(g.mode));
            chk($sformatf("v%0d_alu_out", k), 32'(alu_out), 32'(g.out));
            chk($sformatf("v%0d_flags", k), 32'(flags), 32'(g.flg));
        end

        // The table store (ir=203, 40+40) must have landed in mem[3]
        @(negedge clk);
        stage = 2'd0; ir = 12'h003;
        #1 chk("mem3_after_store", 32'(dmem_do), 32'h80);
        ir = 12'h004;
        #1 chk("mem4_untouched", 32'(dmem_do), 32'h00);

        // Write and read of the same address: old value until the edge
        @(negedge clk);
        stage = 2'd3; ir = 12'h205; acc = 8'h10; dr = 8'h05; sr = 4'h0;
        #1;
        chk("rw_old_value", 32'(dmem_do), 32'h00);
        chk("rw_alu_out", 32'(alu_out), 32'h15);
        @(posedge clk);
        #1 chk("rw_new_value", 32'(dmem_do), 32'h15);
        @(negedge clk);
        stage = 2'd0;

        // Reset coinciding with a store: reset wins and clears everything
        @(negedge clk);
        stage = 2'd3; ir = 12'h206; acc = 8'h22; dr = 8'h11; rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; stage = 2'd0;
        #1 chk("rst_store_mem6", 32'(dmem_do), 32'h00);
        ir = 12'h205;
        #1 chk("rst_clears_mem5", 32'(dmem_do), 32'h00);
        ir = 12'h003;
        #1 chk("rst_clears_mem3", 32'(dmem_do), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
